// File: rtl/gate_checker.sv
// Self-checking sequencer for the two-input gate set: sweeps a/b through 00..11,
// samples the five gate outputs after a settle window and accumulates error statistics.
module gate_checker #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             nand_in,
    input  logic             not_in,
    input  logic             and_in,
    input  logic             or_in,
    input  logic             xor_in,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [4:0]       err_mask,
    output logic [3:0]       vec_fail
);

    localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam int CW       = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_EFF - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      vec;
    logic [CW-1:0]   cnt;
    logic            sample;
    logic            start_ok;
    logic [4:0]      expect_v;
    logic [4:0]      diff;
    logic [2:0]      pop;
    logic [CNT_W:0]  sum;

    assign a = vec[1];
    assign b = vec[0];

    assign sample   = (state == S_SETTLE) && (cnt == LAST);
    assign start_ok = start && (state != S_SETTLE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_SETTLE;
            S_SETTLE: if (sample && (vec == 2'd3)) state_next = S_DONE;
            S_DONE:   if (start) state_next = S_SETTLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == S_SETTLE);
        done = (state == S_DONE);
        pass = (state == S_DONE) && (err_count == '0);
    end

    // Case inequality so that X/Z on a gate output is scored as a mismatch in simulation
    always_comb begin
        expect_v = {~(a & b), ~a, a & b, a | b, a ^ b};
        diff[4]  = (nand_in !== expect_v[4]);
        diff[3]  = (not_in  !== expect_v[3]);
        diff[2]  = (and_in  !== expect_v[2]);
        diff[1]  = (or_in   !== expect_v[1]);
        diff[0]  = (xor_in  !== expect_v[0]);
        pop = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            pop = pop + {2'b00, diff[i]};
        end
        sum = {1'b0, err_count} + (CNT_W + 1)'(pop);
    end

    // Sweep datapath: vector/hold counters and sticky result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec       <= '0;
            cnt       <= '0;
            err_count <= '0;
            err_mask  <= '0;
            vec_fail  <= '0;
        end else if (start_ok) begin
            vec       <= '0;
            cnt       <= '0;
            err_count <= '0;
            err_mask  <= '0;
            vec_fail  <= '0;
        end else if (state == S_SETTLE) begin
            if (sample) begin
                err_mask  <= err_mask | diff;
                vec_fail  <= vec_fail | ({3'b000, |diff} << vec);
                err_count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
                cnt       <= '0;
                if (vec != 2'd3) begin
                    vec <= vec + 2'd1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: model gates (golden or faulted) wired to a/b, table-driven sweeps
// with a scoreboard of expected sweep results, plus hand-written reset/restart sequences.
module tb_gate_checker;

    logic clk;
    logic reset;
    logic start0, start1;
    int   mode0, mode1;

    logic       a0, b0, busy0, done0, pass0;
    logic [4:0] ec0, em0;
    logic [3:0] vf0;
    logic [4:0] gin0;

    logic       a1, b1, busy1, done1, pass1;
    logic [4:0] ec1, em1;
    logic [3:0] vf1;
    logic [4:0] gin1;

    int total;
    int passed;

    typedef struct {
        logic [4:0] cnt;
        logic [4:0] mask;
        logic [3:0] vf;
        logic       pass_e;
    } res_t;

    typedef struct {
        int   sel;
        int   mode;
        res_t res;
    } vec_t;

    typedef struct {
        logic [1:0] ab;
        logic       busy;
        logic       done;
        logic       pass_o;
        logic [4:0] ec;
        logic [4:0] em;
        logic [3:0] vf;
    } obs_t;

    res_t sb[$];

    // mode 0: golden; 1: xor tied 0; 2: nand tied 1 and or inverted
    function automatic logic [4:0] gates(input logic a, input logic b, input int mode);
        logic [4:0] g;
        g = {~(a & b), ~a, a & b, a | b, a ^ b};
        if (mode == 1) g[0] = 1'b0;
        if (mode == 2) begin
            g[4] = 1'b1;
            g[1] = ~(a | b);
        end
        return g;
    endfunction

    always_comb gin0 = gates(a0, b0, mode0);
    always_comb gin1 = gates(a1, b1, mode1);

    gate_checker #(.HOLD_CYCLES(4), .CNT_W(5)) dut4 (
        .clk(clk), .reset(reset), .start(start0),
        .nand_in(gin0[4]), .not_in(gin0[3]), .and_in(gin0[2]), .or_in(gin0[1]), .xor_in(gin0[0]),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(ec0), .err_mask(em0), .vec_fail(vf0)
    );

    gate_checker #(.HOLD_CYCLES(1), .CNT_W(5)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .nand_in(gin1[4]), .not_in(gin1[3]), .and_in(gin1[2]), .or_in(gin1[1]), .xor_in(gin1[0]),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(ec1), .err_mask(em1), .vec_fail(vf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic snap(input int sel, output obs_t o);
        if (sel == 0) begin
            o.ab = {a0, b0}; o.busy = busy0; o.done = done0; o.pass_o = pass0;
            o.ec = ec0; o.em = em0; o.vf = vf0;
        end else begin
            o.ab = {a1, b1}; o.busy = busy1; o.done = done1; o.pass_o = pass1;
            o.ec = ec1; o.em = em1; o.vf = vf1;
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v; else start1 = v;
    endtask

    task automatic check_idle(input int sel, input string tag);
        obs_t o;
        snap(sel, o);
        check($sformatf("%s_ab%0d", tag, sel), 32'(o.ab), 32'd0);
        check($sformatf("%s_busy%0d", tag, sel), 32'(o.busy), 32'd0);
        check($sformatf("%s_done%0d", tag, sel), 32'(o.done), 32'd0);
        check($sformatf("%s_pass%0d", tag, sel), 32'(o.pass_o), 32'd0);
        check($sformatf("%s_ec%0d", tag, sel), 32'(o.ec), 32'd0);
        check($sformatf("%s_em%0d", tag, sel), 32'(o.em), 32'd0);
        check($sformatf("%s_vf%0d", tag, sel), 32'(o.vf), 32'd0);
    endtask

    // One full sweep; extra_at >= 1 drives a stray start just before that edge after E0
    task automatic run_sweep(input int sel, input int mode, input int extra_at, input res_t r,
                             input string tag);
        obs_t o;
        res_t e;
        int   h;
        h = (sel == 0) ? 4 : 1;
        if (sel == 0) mode0 = mode; else mode1 = mode;
        sb.push_back(r);
        set_start(sel, 1'b1);
        tick();
        set_start(sel, 1'b0);
        snap(sel, o);
        check({tag, "_e0_busy"}, 32'(o.busy), 32'd1);
        check({tag, "_e0_done"}, 32'(o.done), 32'd0);
        check({tag, "_e0_ab"}, 32'(o.ab), 32'd0);
        check({tag, "_e0_ec"}, 32'(o.ec), 32'd0);
        check({tag, "_e0_em"}, 32'(o.em), 32'd0);
        for (int j = 1; j <= 4 * h; j++) begin
            if (j == extra_at) set_start(sel, 1'b1);
            tick();
            set_start(sel, 1'b0);
            snap(sel, o);
            if (j < 4 * h) begin
                check($sformatf("%s_ab_e%0d", tag, j), 32'(o.ab), 32'(j / h));
                check($sformatf("%s_done_e%0d", tag, j), 32'(o.done), 32'd0);
            end
        end
        check({tag, "_done"}, 32'(o.done), 32'd1);
        check({tag, "_busy"}, 32'(o.busy), 32'd0);
        check({tag, "_ab_hold"}, 32'(o.ab), 32'd3);
        e = sb.pop_front();
        check({tag, "_err_count"}, 32'(o.ec), 32'(e.cnt));
        check({tag, "_err_mask"}, 32'(o.em), 32'(e.mask));
        check({tag, "_vec_fail"}, 32'(o.vf), 32'(e.vf));
        check({tag, "_pass"}, 32'(o.pass_o), 32'(e.pass_e));
        repeat (3) tick();
        snap(sel, o);
        check({tag, "_stable_ec"}, 32'(o.ec), 32'(e.cnt));
        check({tag, "_stable_done"}, 32'(o.done), 32'd1);
    endtask

    vec_t tbl[5];

    initial begin
        obs_t o;
        res_t good;
        total  = 0;
        passed = 0;
        tbl[0] = '{sel: 0, mode: 0, res: '{cnt: 5'd0, mask: 5'b00000, vf: 4'b0000, pass_e: 1'b1}};
        tbl[1] = '{sel: 0, mode: 1, res: '{cnt: 5'd2, mask: 5'b00001, vf: 4'b0110, pass_e: 1'b0}};
        tbl[2] = '{sel: 0, mode: 2, res: '{cnt: 5'd5, mask: 5'b10010, vf: 4'b1111, pass_e: 1'b0}};
        tbl[3] = '{sel: 1, mode: 1, res: '{cnt: 5'd2, mask: 5'b00001, vf: 4'b0110, pass_e: 1'b0}};
        tbl[4] = '{sel: 1, mode: 0, res: '{cnt: 5'd0, mask: 5'b00000, vf: 4'b0000, pass_e: 1'b1}};
        good = tbl[0].res;

        reset  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        mode0  = 0;
        mode1  = 0;

        // Asynchronous reset takes effect before any clock edge
        #2 reset = 1'b1;
        #1;
        check_idle(0, "rst_async");
        check_idle(1, "rst_async");
        tick();
        tick();
        reset = 1'b0;
        repeat (10) tick();
        check_idle(0, "idle10");
        check_idle(1, "idle10");

        for (int i = 0; i < 3; i++) begin
            run_sweep(tbl[i].sel, tbl[i].mode, -1, tbl[i].res, $sformatf("tbl%0d", i));
        end

        // Stray start at cycle 5 is ignored; timing and results unaffected
        run_sweep(0, 0, 5, good, "midstart");

        // Reset at cycle 6 of a sweep, then a clean sweep
        mode0  = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (6) tick();
        snap(0, o);
        check("midrst_busy_before", 32'(o.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_idle(0, "midrst");
        tick();
        reset = 1'b0;
        tick();
        check_idle(0, "midrst_after");
        run_sweep(0, 0, -1, good, "post_rst");

        // HOLD_CYCLES=1: failed sweep, then restart from DONE with golden gates
        for (int i = 3; i < 5; i++) begin
            run_sweep(tbl[i].sel, tbl[i].mode, -1, tbl[i].res, $sformatf("tbl%0d", i));
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
